// File: rtl/ie_request_capture_pkg.sv
// rtl/ie_request_capture_pkg.sv - shared constants and FSM encoding for the request capture stage
package ie_request_capture_pkg;

    // Entity indices: IE01 owns the upper halves of CH/B, IE02 the lower halves
    localparam int IE01   = 1;
    localparam int IE02   = 0;

    // Per-entity slice widths: entity e owns CH[e*CH_W +: CH_W] and B[e*B_W +: B_W]
    localparam int CH_W   = 4;
    localparam int B_W    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } ie_state_t;

endpackage

// File: rtl/ie_debounce.sv
// rtl/ie_debounce.sv - single-bit two-flop synchronizer with counter debounce and rise pulse
module ie_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it persisted DEB_CYCLES cycles; rise is high the cycle after a 0->1 accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ie_request_capture.sv
// rtl/ie_request_capture.sv - per-entity request latch with debounced presses; IE_REQUEST_LOCK_EN ignores presses while held
module ie_request_capture
    import ie_request_capture_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 250000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] CH_IN,
    input  logic [3:0] B_IN,
    output logic [7:0] CH_OUT,
    output logic [3:0] B_OUT,
    output logic [1:0] VALID,
    output logic [1:0] PRESS
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [7:0] ch_sync1;
    logic [7:0] ch_sync2;
    logic [3:0] b_level;
    logic [3:0] b_rise;

    // Switches are only synchronized; they are sampled once at press time so bounce is irrelevant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ch_sync1 <= '0;
            ch_sync2 <= '0;
        end else begin
            ch_sync1 <= CH_IN;
            ch_sync2 <= ch_sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_deb
        ie_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (CLK),
            .rst   (RST),
            .din   (B_IN[i]),
            .level (b_level[i]),
            .rise  (b_rise[i])
        );
    end

    for (genvar e = IE02; e <= IE01; e++) begin : g_ie
        ie_state_t         state_q;
        ie_state_t         state_n;
        logic [HW-1:0]     cnt_q;
        logic [HW-1:0]     cnt_n;
        logic [CH_W-1:0]   ch_q;
        logic [CH_W-1:0]   ch_n;
        logic [B_W-1:0]    b_q;
        logic [B_W-1:0]    b_n;
        logic              press_q;
        logic              press_n;
        logic              press_evt;
        logic              accept;

        // Both buttons rising together is one event
        assign press_evt = |b_rise[e*B_W +: B_W];

`ifdef IE_REQUEST_LOCK_EN
        assign accept = press_evt && (state_q == IDLE);
`else
        assign accept = press_evt;
`endif

        // Next-state: a press always (re)loads, otherwise count down and clear on expiry
        always_comb begin
            state_n = state_q;
            cnt_n   = cnt_q;
            ch_n    = ch_q;
            b_n     = b_q;
            press_n = 1'b0;
            if (accept) begin
                state_n = HELD;
                cnt_n   = HOLD_LOAD;
                ch_n    = ch_sync2[e*CH_W +: CH_W];
                b_n     = b_level[e*B_W +: B_W];
                press_n = 1'b1;
            end else if (state_q == HELD) begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                    ch_n    = '0;
                    b_n     = '0;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
        end

        // Request state register
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                ch_q    <= '0;
                b_q     <= '0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_n;
                cnt_q   <= cnt_n;
                ch_q    <= ch_n;
                b_q     <= b_n;
                press_q <= press_n;
            end
        end

        assign CH_OUT[e*CH_W +: CH_W] = ch_q;
        assign B_OUT[e*B_W +: B_W]    = b_q;
        assign VALID[e]               = (state_q == HELD);
        assign PRESS[e]               = press_q;
    end

endmodule
